// File: rtl/delay_pipe_pkg.sv
// Shared defaults and helpers for delay_pipe and the blocks that instantiate it.
package delay_pipe_pkg;

  localparam int DP_WIDTH = 8;
  localparam int DP_DEPTH = 4;

  // Bits needed to hold an occupancy value in 0..depth.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/delay_pipe_if.sv
// Valid/ready streaming bundle for delay_pipe: producer side, consumer side and occupancy.
interface delay_pipe_if
  import delay_pipe_pkg::*;
#(
  parameter int WIDTH = DP_WIDTH,
  parameter int DEPTH = DP_DEPTH
) ();

  localparam int CW = cnt_w(DEPTH);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CW-1:0]    count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

endinterface

// File: rtl/delay_pipe_pipe_stage.sv
// One elastic stage: valid bit plus data register with load enable and clear.
// DELAY_PIPE_RESET_DATA_EN gives the data register a reset to RESET_VAL.
module pipe_stage
  import delay_pipe_pkg::*;
#(
  parameter int               WIDTH     = DP_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] data_q;
  logic             data_en;

  always_comb begin
    vld_d = vld_q;
    if (clr_i)     vld_d = 1'b0;
    else if (ld_i) vld_d = vld_i;
  end

  // Data only moves with a real word so bubbles don't toggle the register.
  assign data_en = ld_i & vld_i & ~clr_i;

  always_ff @(posedge clk) begin
    if (rst) vld_q <= 1'b0;
    else     vld_q <= vld_d;
  end

`ifdef DELAY_PIPE_RESET_DATA_EN
  always_ff @(posedge clk) begin
    if (rst)          data_q <= RESET_VAL;
    else if (data_en) data_q <= data_i;
  end
`else
  always_ff @(posedge clk) begin
    if (!rst && data_en) data_q <= data_i;
  end
`endif

  assign vld_o  = vld_q;
  assign data_o = data_q;

endmodule

// File: rtl/delay_pipe.sv
// Elastic DEPTH-stage register pipeline with bubble collapsing, flush and occupancy.
// Optional data reset: DELAY_PIPE_RESET_DATA_EN (handled in pipe_stage).
module delay_pipe
  import delay_pipe_pkg::*;
#(
  parameter int               WIDTH     = DP_WIDTH,
  parameter int               DEPTH     = DP_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  delay_pipe_if.slave  bus
);

  localparam int CW = cnt_w(DEPTH);

  logic [DEPTH-1:0]            vld_q;
  logic [DEPTH-1:0][WIDTH-1:0] data_q;
  logic [DEPTH-1:0]            rdy;
  logic [CW-1:0]               cnt;

  // A stage may load if it or any stage downstream of it has a hole, or the sink takes.
  always_comb begin
    logic acc;
    acc = bus.out_ready;
    rdy = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      acc    = acc | ~vld_q[i];
      rdy[i] = acc;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_v;
    logic [WIDTH-1:0] up_d;
    if (i == 0) begin : g_head
      assign up_v = bus.in_valid;
      assign up_d = bus.in_data;
    end else begin : g_body
      assign up_v = vld_q[i-1];
      assign up_d = data_q[i-1];
    end
    pipe_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (flush),
      .ld_i   (rdy[i]),
      .vld_i  (up_v),
      .data_i (up_d),
      .vld_o  (vld_q[i]),
      .data_o (data_q[i])
    );
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) cnt = cnt + CW'(vld_q[i]);
  end

  assign bus.in_ready  = rdy[0] & ~flush & ~rst;
  assign bus.out_valid = vld_q[DEPTH-1] & ~flush;
  assign bus.out_data  = data_q[DEPTH-1];
  assign bus.count     = cnt;

endmodule

// File: doc/delay_pipe.md
# delay_pipe

Parametrised elastic register pipeline: WIDTH-bit data through DEPTH register stages with per-stage valid bits, valid/ready backpressure, bubble collapsing, synchronous flush and an occupancy count. Generalises the single-bit D flip-flop into the standard retiming/delay element used between datapath blocks wherever a fixed register latency with flow control is needed.

## Interface

- WIDTH, 8, data width in bits (≥1)
- DEPTH, 4, number of register stages (≥1)
- RESET_VAL, '0, data register reset value (used only with DELAY_PIPE_RESET_DATA_EN)

- clk  input  1  clock, rising-edge
- rst  input  1  reset; synchronous, active-high
- flush  input  1  synchronous clear of all stages
- in_valid  input  1  upstream data valid
- in_data  input  WIDTH  upstream data
- in_ready  output  1  pipeline accepts in_data this cycle
- out_valid  output  1  stage DEPTH-1 holds valid data
- out_data  output  WIDTH  data of stage DEPTH-1
- out_ready  input  1  downstream accepts out_data
- count  output  $clog2(DEPTH+1)  number of valid stages

## Operation

- Stage 0 is input side, stage DEPTH-1 drives out_*. Each stage: valid_q[i], data_q[i].
- Ready chain (combinational): rdy[DEPTH] = out_ready; rdy[i] = !valid_q[i] | rdy[i+1]; in_ready = rdy[0] & !flush & !rst.
- Stage i loads when rdy[i]: valid_q[i] ← upstream valid, data_q[i] ← upstream data (stage 0 upstream = in_valid/in_data; else stage i-1). Data registers load only when upstream valid is 1 (no toggling on bubbles).
- Bubbles collapse: a stalled output does not stop upstream stages from filling empty slots.
- Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
- out_valid = valid_q[DEPTH-1] & !flush; out_data = data_q[DEPTH-1].
- count = popcount(valid_q), registered-state based (reflects current contents, not the next cycle's).
- flush: next edge clears all valid_q; input offered in the flush cycle is dropped (in_ready=0); no output transfer in the flush cycle (out_valid=0). Data registers keep their value.
- rst: overrides flush and all transfers; clears all valid_q.

## Timing

- Reset values: out_valid 0, count 0, in_ready 0 while rst high, 1 on first cycle after rst deasserts; out_data = RESET_VAL with macro, else undefined.
- Latency: input accepted at edge N appears on out_valid after edge N+DEPTH-1 (visible cycle N+DEPTH) when unstalled.
- Throughput: one transfer per cycle with out_ready held high; full pipeline with out_ready=1 accepts and emits in same cycle.
- Full: count=DEPTH and out_ready=0 → in_ready=0. Empty: count=0 → out_valid=0, in_ready=1.
- Simultaneous flush and out_ready=1: no output transfer; flush wins.
- rst asserted mid-stream: contents lost at next edge; no partial output.
- DEPTH=1: single elastic register; in_ready = !valid_q[0] | out_ready.

## Configuration

- DELAY_PIPE_RESET_DATA_EN defined: rst also loads data_q[*] ← RESET_VAL; out_data deterministic after reset.
- Undefined: data registers have no reset (valid bits only); out_data is don't-care whenever out_valid=0. Functional behaviour at valid/ready interface identical.

## Structure

- Package delay_pipe_pkg: default WIDTH/DEPTH constants and a count-width function ($clog2(DEPTH+1)) shared with instantiating blocks.
- Sub-module pipe_stage: one valid/data register with load enable and optional reset data; delay_pipe instantiates DEPTH of them via generate and builds the ready chain and count.

## Test plan

- Reset: hold rst 3 cycles with in_valid=1 → out_valid=0, count=0, in_ready=0; release → in_ready=1.
- Streaming: DEPTH=4, out_ready=1, push 0x01..0x10 back-to-back → 0x01 at out first visible 4 cycles after its accept, then one word/cycle, order preserved.
- Backpressure: out_ready=0, push 6 words → 4 accepted, count=4, in_ready=0; raise out_ready → words 1..4 drain in order, then 5,6.
- Bubble collapse: push word A, one idle cycle, word B, out_ready=0 → after 4 cycles both in stages 3 and 2 adjacently, count=2.
- Flush: count=3, assert flush with in_valid=1 and out_ready=1 for one cycle → no transfers that cycle, next cycle count=0, out_valid=0.
- Macro: with DELAY_PIPE_RESET_DATA_EN, RESET_VAL=0xA5 → out_data=0xA5 after reset; without, only valid/count checked.
